rv32m_iter_muldiv: RTL and testbench

- RV32M execution unit that produces ALUResult_M and Zero_M for the downstream RV32I/RV32M result select mux.
- Multiply ops (MUL/MULH/MULHSU/MULHU) finish in one cycle.
- Divide/remainder ops (DIV/DIVU/REM/REMU) use a 32-iteration restoring divider.
- busy drives the core's PC/regfile-write stall while an op is in flight.

---
 rtl/rv32m_iter_muldiv_pkg.sv | 35 +++
 rtl/rv32m_iter_muldiv_if.sv | 21 ++
 rtl/rv32m_iter_muldiv_div_core.sv | 61 ++++++
 rtl/rv32m_iter_muldiv.sv | 138 +++++++++++++
 tb/tb_rv32m_iter_muldiv.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_iter_muldiv_pkg.sv
// Shared encodings for the RV32M execution unit: funct3 ops, FSM states,
// divider iteration count and the latched divide context.
package rv32m_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    FINISH  = 2'd2
  } state_t;

  // What the FINISH state needs to turn the unsigned core result into
  // the architectural answer.
  typedef struct packed {
    logic is_rem;
    logic q_neg;
    logic r_neg;
  } div_ctx_t;

  // funct3[0] clear marks the signed divide ops (DIV, REM).
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/rv32m_iter_muldiv_if.sv
// Core <-> RV32M unit handshake and result bus.
interface rv32m_iter_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult_M;
  logic             Zero_M;

  modport master (
    output start, funct3, SrcA, SrcB,
    input  busy, done, ALUResult_M, Zero_M
  );

  modport slave (
    input  start, funct3, SrcA, SrcB,
    output busy, done, ALUResult_M, Zero_M
  );
endinterface

// File: rtl/rv32m_iter_muldiv_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per run cycle.
// The quotient register starts as the dividend and shifts the quotient
// bits in from the bottom as the dividend bits leave through the top.
module rv32m_div_core
  import rv32m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted, diff;

  // Trial subtract of the divisor from the shifted partial remainder;
  // a borrow (diff MSB) means this quotient bit is zero.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Load operands on accept, then iterate once per run cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (run) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CW'(DIV_ITERS - 1));

endmodule

// File: rtl/rv32m_iter_muldiv.sv
// RV32M execution unit: single-cycle multiplies and divide special cases,
// 32-iteration restoring divide for everything else. busy stalls the core
// while the divider iterates; done pulses when ALUResult_M is fresh.
module rv32m_iter_muldiv
  import rv32m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  rv32m_iter_muldiv_if.slave    bus
);

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state_q, state_nxt;
  div_ctx_t          ctx_q;
  logic              done_q, zero_q;
  logic [WIDTH-1:0]  res_q, res_nxt;
  logic              res_we, div_load, div_run, div_last;

  logic [2:0]        f3;
  logic [WIDTH-1:0]  a, b;
  logic              is_div, sdiv, is_rem, b_zero, ovf;
  logic              a_sx, b_sx, a_neg, b_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  mul_res, spec_res, dvd_abs, dvs_abs;
  logic [WIDTH-1:0]  quo, rem, fin_q, fin_r, fin_res;

  assign f3 = bus.funct3;
  assign a  = bus.SrcA;
  assign b  = bus.SrcB;

  // Op decode, multiplier and divide special-case results.
  always_comb begin
    is_div = f3[2];
    sdiv   = is_signed_div(f3);
    is_rem = f3[1];
    b_zero = (b == '0);
    ovf    = sdiv && (a == INT_MIN) && (b == '1);

    a_sx = ((f3 == MULH) || (f3 == MULHSU)) && a[WIDTH-1];
    b_sx = (f3 == MULH) && b[WIDTH-1];
    prod = {{WIDTH{a_sx}}, a} * {{WIDTH{b_sx}}, b};
    mul_res = (f3 == MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

    if (b_zero) spec_res = is_rem ? a : '1;
    else        spec_res = is_rem ? '0 : INT_MIN;

    a_neg   = sdiv && a[WIDTH-1];
    b_neg   = sdiv && b[WIDTH-1];
    dvd_abs = a_neg ? -a : a;
    dvs_abs = b_neg ? -b : b;
  end

  rv32m_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .run       (div_run),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  // Sign fix-up of the unsigned core result and quotient/remainder select.
  always_comb begin
    fin_q   = ctx_q.q_neg ? -quo : quo;
    fin_r   = ctx_q.r_neg ? -rem : rem;
    fin_res = ctx_q.is_rem ? fin_r : fin_q;
  end

  // Next-state and result-write decisions.
  always_comb begin
    state_nxt = state_q;
    res_we    = 1'b0;
    res_nxt   = '0;
    div_load  = 1'b0;
    div_run   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!is_div) begin
            res_we  = 1'b1;
            res_nxt = mul_res;
          end else if (b_zero || ovf) begin
            res_we  = 1'b1;
            res_nxt = spec_res;
          end else begin
            div_load  = 1'b1;
            state_nxt = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        div_run = 1'b1;
        if (div_last) state_nxt = FINISH;
      end
      FINISH: begin
        res_we    = 1'b1;
        res_nxt   = fin_res;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, done pulse, result and divide context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ctx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      done_q  <= res_we;
      if (res_we) begin
        res_q  <= res_nxt;
        zero_q <= (res_nxt == '0);
      end
      if (div_load) begin
        ctx_q.is_rem <= is_rem;
        ctx_q.q_neg  <= a_neg ^ b_neg;
        ctx_q.r_neg  <= a_neg;
      end
    end
  end

  assign bus.busy        = (state_q == DIV_RUN);
  assign bus.done        = done_q;
  assign bus.ALUResult_M = res_q;
  assign bus.Zero_M      = zero_q;

endmodule

// File: tb/tb_rv32m_iter_muldiv.sv
// Bench for rv32m_iter_muldiv: vector table plus random ops against a
// reference model, scoreboard queue, and hand sequences for reset abort,
// start re-pulse while busy, and back-to-back issue.
module tb_rv32m_iter_muldiv;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rv32m_iter_muldiv_if #(.WIDTH(32)) bus ();

  rv32m_iter_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, want);
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ai, bi;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'h0, a});  ub = longint'({32'h0, b});
    ai = int'(a); bi = int'(b);
    case (f)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:  begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ai / bi);
      end
      DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      REM:  begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ai % bi);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2] || b == 0) return 0;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
    return 33;
  endfunction

  // Drive one start pulse; on return we are #1 after the accepting edge.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.SrcA = a; bus.SrcB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] res, input int lat, input string nm);
    exp_t e;
    e.res = res; e.lat = lat; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  task automatic wait_done(input int lat0, input int bc0);
    int lat, bc;
    exp_t e;
    lat = lat0; bc = bc0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.nm, "_done_seen"}, 32'(bus.done), 32'd1);
    chk({e.nm, "_result"}, bus.ALUResult_M, e.res);
    chk({e.nm, "_zero"}, 32'(bus.Zero_M), 32'(e.res == 0));
    chk({e.nm, "_latency"}, 32'(lat), 32'(e.lat));
    chk({e.nm, "_busy_cycles"}, 32'(bc), (e.lat == 33) ? 32'd32 : 32'd0);
  endtask

  task automatic add(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int lat, input string nm);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.res = res; v.lat = lat; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    int dcnt;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    bus.start = 1'b0; bus.funct3 = '0; bus.SrcA = '0; bus.SrcB = '0;

    add(MULH,   32'h80000000, 32'h80000000, 32'h40000000,  0, "mulh_min");
    add(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  0, "mulhsu_m1");
    add(MUL,    32'd7,        32'd6,        32'd42,        0, "mul_7x6");
    add(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  0, "mulhu_max");
    add(MUL,    32'd0,        32'h12345678, 32'd0,         0, "mul_zero");
    add(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
    add(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
    add(DIVU,   32'd100,      32'd7,        32'd14,       33, "divu_100_7");
    add(REMU,   32'd100,      32'd7,        32'd2,        33, "remu_100_7");
    add(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2");
    add(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem_7_m2");
    add(DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "divu_max_1");
    add(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF,  0, "divu_by0");
    add(REM,    32'd5,        32'd0,        32'd5,         0, "rem_by0");
    add(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000,  0, "div_ovf");
    add(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,         0, "rem_ovf");

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.ALUResult_M, 32'd0);
    chk("rst_zero", 32'(bus.Zero_M), 32'd1);

    // Vector table.
    foreach (tbl[i]) begin
      push_exp(tbl[i].res, tbl[i].lat, tbl[i].nm);
      launch(tbl[i].f, tbl[i].a, tbl[i].b);
      wait_done(0, 0);
      @(posedge clk); #1;
      chk({tbl[i].nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    end

    // Random ops against the reference model.
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      push_exp(model_res(rf, ra, rb), model_lat(rf, ra, rb), "rand");
      launch(rf, ra, rb);
      wait_done(0, 0);
    end

    // start re-pulsed with other operands during DIV_RUN is ignored.
    push_exp(32'd14, 33, "repulse");
    launch(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = REM; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
    repeat (3) @(posedge clk);
    #1; bus.start = 1'b0;
    wait_done(3, 3);

    // Back-to-back: second start issued in the done cycle of the first.
    push_exp(32'hFFFFFFFD, 33, "b2b_first");
    launch(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(0, 0);
    push_exp(32'd2, 33, "b2b_second");
    launch(REMU, 32'd100, 32'd7);
    wait_done(0, 0);

    // Reset at iteration 10 aborts the divide with no done pulse.
    launch(DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.ALUResult_M, 32'd0);
    chk("abort_zero", 32'(bus.Zero_M), 32'd1);
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
